// File: rtl/modulation_az_seq.sv
// Auto-zero modulation sequencer: alternates pc-out signal samples with lo (zero)
// channel samples through precharge/settle phases, with registered control outputs.
module modulation_az_seq #(
    parameter int MUX_W = 4,
    parameter int N_LO = 4,
    parameter int CNT_W = 32,
    parameter logic [MUX_W-1:0] PC_OUT_VAL = 4'b1000,
    localparam int NLO_W = $clog2(N_LO + 1),
    localparam int IDX_W = (N_LO > 1) ? $clog2(N_LO) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [1:0]             mode,
    input  logic [N_LO*MUX_W-1:0]  az_lo_vals,
    input  logic [NLO_W-1:0]       n_lo,
    input  logic [CNT_W-1:0]       clk_count_sample_n,
    input  logic [CNT_W-1:0]       clk_count_precharge_n,
    output logic                   sw_pc_ctl,
    output logic [MUX_W-1:0]       azmux,
    output logic                   sample_done,
    output logic                   sample_is_lo,
    output logic [IDX_W-1:0]       sample_idx,
    output logic                   led0,
    output logic [7:0]             monitor
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BOOT      = 3'd1,
        S_SETTLE    = 3'd2,
        S_SIG       = 3'd3,
        S_REPROTECT = 3'd4,
        S_LO        = 3'd5,
        S_WRAP      = 3'd6
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [1:0]        mode_l, mode_l_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic [NLO_W-1:0]  n_lo_eff;
    logic [MUX_W-1:0]  lo_sel;
    logic              sw_nx, done_nx, is_lo_nx, led_nx;
    logic [MUX_W-1:0]  azmux_nx;
    logic [7:0]        mon_nx;

    // The counter holds clocks remaining after the current one, so a count of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                  input logic [NLO_W-1:0] lim);
        return ((NLO_W'(cur) + NLO_W'(1)) >= lim) ? '0 : cur + IDX_W'(1);
    endfunction

    always_comb begin
        n_lo_eff = n_lo;
        if (n_lo == '0 || n_lo > NLO_W'(N_LO)) n_lo_eff = NLO_W'(N_LO);
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mode_l_nx = mode_l;
        idx_nx    = sample_idx;
        case (state)
            S_IDLE: begin
                if (run && mode != 2'd0) begin
                    state_nx  = S_BOOT;
                    cnt_nx    = reload(clk_count_precharge_n);
                    mode_l_nx = mode;
                    idx_nx    = '0;
                end
            end
            S_BOOT: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else begin
                    state_nx = S_SETTLE;
                    cnt_nx   = reload(clk_count_precharge_n);
                end
            end
            S_SETTLE: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else begin
                    state_nx = S_SIG;
                    cnt_nx   = reload(clk_count_sample_n);
                end
            end
            S_SIG: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else if (mode_l == 2'd1) begin
                    state_nx = S_WRAP;
                    cnt_nx   = '0;
                end else begin
                    state_nx = S_REPROTECT;
                    cnt_nx   = reload(clk_count_precharge_n);
                end
            end
            S_REPROTECT: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else begin
                    state_nx = S_LO;
                    cnt_nx   = reload(clk_count_sample_n);
                end
            end
            S_LO: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else begin
                    state_nx = S_WRAP;
                    cnt_nx   = '0;
                end
            end
            S_WRAP: begin
                // Run/mode requests are only honoured here so a cycle is never cut short.
                if (!run || mode == 2'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (mode != mode_l) begin
                    state_nx  = S_BOOT;
                    cnt_nx    = reload(clk_count_precharge_n);
                    mode_l_nx = mode;
                    idx_nx    = '0;
                end else if (mode_l == 2'd1) begin
                    state_nx = S_SIG;
                    cnt_nx   = reload(clk_count_sample_n);
                end else begin
                    state_nx = S_SETTLE;
                    cnt_nx   = reload(clk_count_precharge_n);
                    if (mode_l == 2'd3) idx_nx = next_idx(sample_idx, n_lo_eff);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        lo_sel = PC_OUT_VAL;
        for (int k = 0; k < N_LO; k++) begin
            if (int'(idx_nx) == k) lo_sel = az_lo_vals[k*MUX_W +: MUX_W];
        end
    end

    // Outputs are decoded from the next state so the registered values line up with the state.
    always_comb begin
        sw_nx    = (state_nx == S_SIG) || (state_nx == S_WRAP && mode_l_nx == 2'd1);
        azmux_nx = (state_nx == S_LO) ? lo_sel : PC_OUT_VAL;
        done_nx  = (state_nx == S_SIG || state_nx == S_LO) && cnt_nx == '0;
        is_lo_nx = (state_nx == S_LO) && cnt_nx == '0;
        led_nx   = (state_nx == S_SIG);
        mon_nx   = {state_nx == S_WRAP, state_nx, state_nx == S_LO, done_nx, sw_nx,
                    azmux_nx == PC_OUT_VAL};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mode_l       <= 2'd0;
            sample_idx   <= '0;
            sw_pc_ctl    <= 1'b0;
            azmux        <= PC_OUT_VAL;
            sample_done  <= 1'b0;
            sample_is_lo <= 1'b0;
            led0         <= 1'b0;
            monitor      <= 8'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            mode_l       <= mode_l_nx;
            sample_idx   <= idx_nx;
            sw_pc_ctl    <= sw_nx;
            azmux        <= azmux_nx;
            sample_done  <= done_nx;
            sample_is_lo <= is_lo_nx;
            led0         <= led_nx;
            monitor      <= mon_nx;
        end
    end

endmodule

// File: doc/modulation_az_seq.md
MODULATION_AZ_SEQ -- requirements
Module: modulation_az_seq

Interface
REQ-001 Parameter MUX_W, default 4, SHALL set the azmux width.
REQ-002 Parameter N_LO, default 4, SHALL set the number of lo (zero) channels held in az_lo_vals.
REQ-003 Parameter CNT_W, default 32, SHALL set the phase-counter width.
REQ-004 Parameter PC_OUT_VAL, default 4'b1000, SHALL be the azmux code selecting pc-out.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- run  in  1  level; 1 = sequence enabled.
- mode  in  2  0 idle, 1 no-AZ, 2 AZ single lo, 3 AZ cycling lo.
- az_lo_vals  in  N_LO*MUX_W  packed lo codes; channel k at bits [k*MUX_W +: MUX_W].
- n_lo  in  clog2(N_LO+1)  active lo channels for mode 3.
- clk_count_sample_n  in  CNT_W  sample-phase length in clocks.
- clk_count_precharge_n  in  CNT_W  precharge/settle-phase length in clocks.
- sw_pc_ctl  out  1  1 = signal, 0 = boot.
- azmux  out  MUX_W  az mux select.
- sample_done  out  1  one-clock strobe on the last clock of a sample phase.
- sample_is_lo  out  1  qualifies sample_done; 0 = hi (signal) sample.
- sample_idx  out  clog2(N_LO)  lo channel of the current/last lo sample.
- led0  out  1  1 during hi half-cycle.
- monitor  out  8  debug bus.

Function
REQ-006 States SHALL be IDLE, BOOT, SETTLE, SIG, REPROTECT, LO, WRAP.
REQ-007 Each timed phase (BOOT, SETTLE, SIG, REPROTECT, LO) SHALL last exactly max(N,1) clocks, where N is the relevant count input latched on phase entry; a count of 0 SHALL be treated as 1.
REQ-008 Count inputs changed mid-phase SHALL NOT affect the phase in progress.
REQ-009 IDLE: sw_pc_ctl=0, azmux=PC_OUT_VAL, no strobes; exit to BOOT when run=1 and mode!=0.
REQ-010 BOOT (precharge length): sw_pc_ctl=0, then to SETTLE.
REQ-011 SETTLE (precharge length): azmux=PC_OUT_VAL, sw_pc_ctl=0, then to SIG.
REQ-012 SIG (sample length): sw_pc_ctl=1, led0=1, sample_done=1 with sample_is_lo=0 on its final clock; then to REPROTECT (modes 2/3) or to WRAP (mode 1).
REQ-013 REPROTECT (precharge length): sw_pc_ctl=0, then to LO.
REQ-014 LO (sample length): azmux=az_lo_vals[sample_idx], led0=0, sample_done=1 with sample_is_lo=1 on its final clock; then to WRAP.
REQ-015 Mode 1 SHALL hold sw_pc_ctl=1 across WRAP into the next SIG with no return through SETTLE, giving back-to-back hi samples separated by one WRAP clock.
REQ-016 WRAP (one clock): if run=0 or mode=0 go to IDLE; if mode changed since the last BOOT go to BOOT; else go to SETTLE (modes 2/3) or SIG (mode 1).
REQ-017 Mode 2 SHALL hold sample_idx=0.
REQ-018 Mode 3 SHALL increment sample_idx in WRAP after each LO, wrapping to 0 when it reaches n_lo-1; n_lo=0 or n_lo>N_LO SHALL be treated as N_LO.
REQ-019 Mode 3 entry from IDLE or BOOT SHALL start at sample_idx=0.
REQ-020 Deasserting run or changing mode mid-cycle SHALL NOT truncate the cycle; it takes effect only at WRAP.
REQ-021 The mode value SHALL be latched at BOOT; mode 0 seen at WRAP SHALL mean IDLE.
REQ-022 monitor mapping SHALL be:
- [0] azmux==PC_OUT_VAL.
- [1] sw_pc_ctl.
- [2] sample_done.
- [3] state==LO.
- [6:4] state code.
- [7] state==WRAP.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 With reset=0 at posedge clk, the block SHALL enter IDLE with sw_pc_ctl=0, azmux=PC_OUT_VAL, sample_done=0, sample_is_lo=0, sample_idx=0, led0=0, monitor=0, and counters cleared.
REQ-025 Reset asserted mid-phase SHALL abort that phase with no sample_done strobe; after release, at least one BOOT phase SHALL occur before any SIG.

Verification
REQ-026 mode=2, precharge_n=3, sample_n=5, az_lo_vals[0]=4'b0010: sequence 3 BOOT, 3 SETTLE, 5 SIG, 3 REPROTECT, 5 LO, 1 WRAP; period 17 clocks; exactly one hi and one lo strobe per period.
REQ-027 mode=3, n_lo=3: lo azmux codes cycle ch0, ch1, ch2, ch0 over consecutive periods; sample_idx equals the channel on each lo strobe.
REQ-028 mode=1, sample_n=4: sw_pc_ctl stays 1 after the first SIG; hi strobes every 5 clocks; no lo strobes.
REQ-029 Drop run during SIG: cycle completes through LO and WRAP, then IDLE with sw_pc_ctl=0; change sample_n mid-SIG: current SIG length is unchanged.
REQ-030 reset=0 pulsed for one clock mid-LO: no strobe; outputs take reset values; after release with run=1, BOOT occurs before SIG.
